// File: rtl/mealy_seq_detector.sv
// -----------------------------------------------------------------------------
// mealy_seq_detector
//   Runtime-programmable Mealy sequence detector. Watches a serial bit stream
//   (qualified by in_valid) for a PAT_W-bit pattern loaded at runtime, with
//   overlapping or non-overlapping detection selected at load time.
//
//   Optional feature macro: MEALY_MATCH_CNT_EN
//     defined   -> saturating match counter (match_cnt / cnt_sat) is built
//     undefined -> no counter flops; match_cnt and cnt_sat tie to 0
//
// Ports
//   clk          in   single clock, posedge
//   rst_n        in   asynchronous active-low reset
//   in_valid     in   qualifies in_bit this cycle
//   in_bit       in   serial data bit
//   cfg_load     in   latch pattern / cfg_overlap, clear history (wins over in_valid)
//   pattern      in   PAT_W-bit pattern, pattern[PAT_W-1] is the first bit received
//   cfg_overlap  in   1 = overlapping detection, 0 = non-overlapping
//   match        out  combinational Mealy output, high in the cycle of the last bit
//   match_q      out  match delayed by one clock
//   fill         out  FSM state: number of valid history bits held (0..PAT_W)
//   match_cnt    out  saturating count of matches
//   cnt_sat      out  high while match_cnt is all-ones
// -----------------------------------------------------------------------------
module mealy_seq_detector #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic                       in_bit,
  input  logic                       cfg_load,
  input  logic [PAT_W-1:0]           pattern,
  input  logic                       cfg_overlap,
  output logic                       match,
  output logic                       match_q,
  output logic [$clog2(PAT_W+1)-1:0] fill,
  output logic [CNT_W-1:0]           match_cnt,
  output logic                       cnt_sat
);

  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] FILL_ARM  = FILL_W'(PAT_W - 1);

  // Coarse view of the fill-level FSM: a match is only possible once enough
  // history has been collected that the current bit completes a full window.
  typedef enum logic {
    ST_PRIME = 1'b0,
    ST_ARMED = 1'b1
  } arm_t;

  logic [PAT_W-1:0]  r_pat;
  logic              r_overlap;
  logic [PAT_W-2:0]  r_hist;
  logic [FILL_W-1:0] r_fill;
  logic              r_match_q;

  logic [FILL_W-1:0] w_fill_eff;
  logic [FILL_W-1:0] w_fill_nxt;
  logic [PAT_W-2:0]  w_hist_nxt;
  logic [PAT_W-1:0]  w_window;
  logic              w_shift_en;
  logic              w_match;
  arm_t              w_arm;

  // Unreachable encodings above PAT_W collapse to S0.
  assign w_fill_eff = (r_fill > FILL_FULL) ? '0 : r_fill;
  assign w_arm      = (w_fill_eff >= FILL_ARM) ? ST_ARMED : ST_PRIME;

  // Candidate window: stored history with the live bit appended as the newest.
  // Taking the low PAT_W-1 bits of it is also the shifted history, which keeps
  // PAT_W=2 (1-bit history) free of negative slices.
  assign w_window   = {r_hist, in_bit};
  assign w_shift_en = in_valid & ~cfg_load;
  assign w_match    = w_shift_en & (w_arm == ST_ARMED) & (w_window == r_pat);

  // Configuration registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pat     <= '0;
      r_overlap <= 1'b1;
    end else if (cfg_load) begin
      r_pat     <= pattern;
      r_overlap <= cfg_overlap;
    end
  end

  // FSM state register (fill level) plus history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fill    <= '0;
      r_hist    <= '0;
      r_match_q <= 1'b0;
    end else begin
      r_fill    <= w_fill_nxt;
      r_hist    <= w_hist_nxt;
      r_match_q <= w_match;
    end
  end

  // Next-state logic
  always_comb begin
    w_fill_nxt = w_fill_eff;
    w_hist_nxt = r_hist;
    if (cfg_load) begin
      w_fill_nxt = '0;
      w_hist_nxt = '0;
    end else if (in_valid) begin
      if (w_match && !r_overlap) begin
        // Non-overlapping: the matched bits may not seed the next match.
        w_fill_nxt = '0;
        w_hist_nxt = '0;
      end else if (w_match) begin
        w_fill_nxt = FILL_FULL;
        w_hist_nxt = w_window[PAT_W-2:0];
      end else begin
        w_fill_nxt = (w_fill_eff >= FILL_FULL) ? FILL_FULL
                                               : w_fill_eff + FILL_W'(1);
        w_hist_nxt = w_window[PAT_W-2:0];
      end
    end
  end

  assign match   = w_match;
  assign match_q = r_match_q;
  assign fill    = r_fill;

`ifdef MEALY_MATCH_CNT_EN
  logic [CNT_W-1:0] r_cnt;

  // Saturating counter: sticks at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_match && !(&r_cnt)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign match_cnt = r_cnt;
  assign cnt_sat   = &r_cnt;
`else
  assign match_cnt = '0;
  assign cnt_sat   = 1'b0;
`endif

endmodule
